fabric_load_mem_arbiter: RTL

//  Shares one memory read port among NUM_REQ load PEs. Round-robin arbitrates the PEs'

---
 rtl/fabric_pkg.sv | 17 +
 rtl/fabric_rr_arbiter.sv | 32 +++
 rtl/fabric_load_mem_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fabric_pkg.sv
// Shared definitions for the load fabric: safe width helper and error codes.
package fabric_pkg;

    // Elaboration-time error codes for illegal parameter values
    localparam int COMP_LOADARB_NUM_REQ         = 101;
    localparam int COMP_LOADARB_DATA_WIDTH      = 102;
    localparam int COMP_LOADARB_MAX_OUTSTANDING = 103;

    // Runtime error code: a memory response arrived with nothing outstanding
    localparam int RT_LOADARB_UNEXP_RSP = 201;

    // $clog2 that never returns 0, so single-entry structures still get a 1-bit index
    function automatic int clog2_safe(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fabric_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module fabric_rr_arbiter
    import fabric_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    // Scan from ptr upward modulo NUM_REQ and pick the first asserted request
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fabric_load_mem_arbiter.sv
// Shares one in-order memory read port among NUM_REQ load PEs.
// Requests are round-robin arbitrated; winner IDs are queued in order so each
// memory response is steered back to the PE that issued it.
//
// Handshakes: every channel uses valid/ready. A transfer happens on a rising
// clk edge where both valid and ready are 1. A producer must hold valid (and
// its payload) stable until the transfer; ready may depend combinationally on
// valid. Both request and response paths are zero latency.
module fabric_load_mem_arbiter
    import fabric_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [DATA_WIDTH-1:0]         mem_req_addr,
    input  logic                          mem_rsp_valid,
    output logic                          mem_rsp_ready,
    input  logic [DATA_WIDTH-1:0]         mem_rsp_data,
    output logic                          err_unexp_rsp
);

    localparam int ID_W  = clog2_safe(NUM_REQ);
    localparam int PTR_W = clog2_safe(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // Reject illegal parameterisations at elaboration
    if (NUM_REQ < 1) begin : g_bad_num_req
        $fatal(1, "code %0d: NUM_REQ must be >= 1", COMP_LOADARB_NUM_REQ);
    end
    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $fatal(1, "code %0d: DATA_WIDTH must be >= 1", COMP_LOADARB_DATA_WIDTH);
    end
    if (MAX_OUTSTANDING < 1) begin : g_bad_max_out
        $fatal(1, "code %0d: MAX_OUTSTANDING must be >= 1", COMP_LOADARB_MAX_OUTSTANDING);
    end

    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_valid;

    logic [ID_W-1:0]    id_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [ID_W-1:0]    head;

    logic full;
    logic empty;
    logic push;
    logic pop;

    fabric_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign full  = (count == CNT_W'(MAX_OUTSTANDING));
    assign empty = (count == '0);
    assign head  = id_fifo[rd_ptr];

    // Request path: forward the grantee's address unless the ID FIFO is full
    always_comb begin
        mem_req_valid = grant_valid && !full;
        mem_req_addr  = req_addr[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        req_ready     = (mem_req_ready && !full) ? grant : '0;
    end

    assign push = mem_req_valid && mem_req_ready;

    // Response path: steer the in-order response to the PE at the FIFO head
    always_comb begin
        rsp_valid     = '0;
        mem_rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!empty && (head == ID_W'(i))) begin
                rsp_valid[i]  = mem_rsp_valid;
                mem_rsp_ready = rsp_ready[i];
            end
        end
    end

    assign rsp_data = {NUM_REQ{mem_rsp_data}};
    assign pop      = mem_rsp_valid && mem_rsp_ready;

    // Round-robin pointer moves past the winner only when the request is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // ID storage needs no reset: entries are only read between push and pop
    always_ff @(posedge clk) begin
        if (push) begin
            id_fifo[wr_ptr] <= grant_idx;
        end
    end

    // FIFO pointers and occupancy; pointers wrap at the (possibly non-pow2) depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Sticky flag for a response with nothing outstanding (RT_LOADARB_UNEXP_RSP)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_unexp_rsp <= 1'b0;
        end else if (mem_rsp_valid && empty) begin
            err_unexp_rsp <= 1'b1;
        end
    end

endmodule
